// File: rtl/rom_bank_mapper_if.sv
// rtl/rom_bank_mapper_if.sv - toggle-handshake memory port between rom_bank_mapper and ddram
interface rom_bank_mapper_if #(
    parameter int MEM_W  = 25,
    parameter int DATA_W = 16
);
    logic [MEM_W-2:0]  mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we_req;
    logic              mem_we_ack;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_addr, mem_din, mem_we_req, mem_rd_req,
        input  mem_we_ack, mem_rd_ack, mem_dout
    );

    modport slave (
        input  mem_addr, mem_din, mem_we_req, mem_rd_req,
        output mem_we_ack, mem_rd_ack, mem_dout
    );
endinterface

// File: rtl/rom_bank_mapper.sv
// rtl/rom_bank_mapper.sv - N-bank ROM mapper, download write path and single-outstanding memory arbiter
// Optional ROM mirroring mask on reads: define ROM_MAPPER_SIZE_MASK_EN.
module rom_bank_mapper #(
    parameter  int ADDR_W     = 22,
    parameter  int BANK_SHIFT = 19,
    parameter  int PAGE_W     = 6,
    parameter  int DATA_W     = 16,
    parameter  int LOCK_BANK0 = 1,
    localparam int BANK_IDX_W = ADDR_W - BANK_SHIFT,
    localparam int MEM_W      = BANK_SHIFT + PAGE_W
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  map_we,
    input  logic [BANK_IDX_W-1:0] map_a,
    input  logic [PAGE_W-1:0]     map_d,
    input  logic [ADDR_W-2:0]     cpu_addr,
    input  logic                  cpu_req,
    output logic                  cpu_ack,
    output logic [DATA_W-1:0]     cpu_dout,
    input  logic                  dl_active,
    input  logic                  dl_wr,
    input  logic [MEM_W-1:0]      dl_addr,
    input  logic [DATA_W-1:0]     dl_data,
    output logic                  dl_wait,
    output logic                  dl_overrun,
`ifdef ROM_MAPPER_SIZE_MASK_EN
    input  logic [MEM_W-2:0]      rom_mask,
`endif
    rom_bank_mapper_if.master     mem
);
    localparam int NBANK = 1 << BANK_IDX_W;
    localparam int MA_W  = MEM_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PAGE_W-1:0] bank_q [NBANK];
    logic [PAGE_W-1:0] bank_d [NBANK];
    logic              use_map_q, use_map_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              wr_pend_q, wr_pend_d;
    logic              overrun_q, overrun_d;
    logic [MA_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_we_req_q, mem_we_req_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic              dl_active_q;
    logic [MA_W-1:0]   xlate_addr;
    logic [MA_W-1:0]   rd_addr;
    logic              rd_pend;
    logic              we_done;
    logic              rd_done;
    logic              unused_dl_addr_lsb;

    assign unused_dl_addr_lsb = dl_addr[0];
    assign rd_pend = cpu_req != cpu_ack_q;
    assign we_done = mem.mem_we_ack == mem_we_req_q;
    assign rd_done = mem.mem_rd_ack == mem_rd_req_q;

    always_comb begin
        if (use_map_q) begin
            xlate_addr = {bank_q[cpu_addr[ADDR_W-2:BANK_SHIFT-1]], cpu_addr[BANK_SHIFT-2:0]};
        end else begin
            xlate_addr = MA_W'(cpu_addr);
        end
    end

`ifdef ROM_MAPPER_SIZE_MASK_EN
    assign rd_addr = xlate_addr & rom_mask;
`else
    assign rd_addr = xlate_addr;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_pend_q)    state_d = S_WR_WAIT;
                else if (rd_pend) state_d = S_RD_WAIT;
            end
            S_WR_WAIT: if (we_done)            state_d = S_IDLE;
            S_RD_WAIT: if (rd_done)            state_d = S_IDLE;
            S_DRAIN:   if (we_done && rd_done) state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bank_d       = bank_q;
        use_map_d    = use_map_q;
        cpu_dout_d   = cpu_dout_q;
        cpu_ack_d    = cpu_ack_q;
        wr_pend_d    = wr_pend_q;
        overrun_d    = overrun_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_req_d = mem_we_req_q;
        mem_rd_req_d = mem_rd_req_q;

        if (map_we && ((map_a != '0) || (LOCK_BANK0 == 0))) begin
            bank_d[map_a] = map_d;
            use_map_d     = 1'b1;
        end

        if (dl_active && !dl_active_q) overrun_d = 1'b0;

        // The capture slot is separate from mem_addr so a download can land while a read is in flight.
        if (dl_wr) begin
            if (!wr_pend_q) begin
                wr_addr_d = dl_addr[MEM_W-1:1];
                wr_data_d = {dl_data[DATA_W/2-1:0], dl_data[DATA_W-1:DATA_W/2]};
                wr_pend_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wr_pend_q) begin
                    mem_addr_d   = wr_addr_q;
                    mem_din_d    = wr_data_q;
                    mem_we_req_d = ~mem_we_req_q;
                end else if (rd_pend) begin
                    mem_addr_d   = rd_addr;
                    mem_rd_req_d = ~mem_rd_req_q;
                end
            end
            S_WR_WAIT: if (we_done) wr_pend_d = 1'b0;
            S_RD_WAIT: begin
                if (rd_done) begin
                    cpu_dout_d = mem.mem_dout;
                    cpu_ack_d  = ~cpu_ack_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= (!we_done || !rd_done) ? S_DRAIN : S_IDLE;
            for (int i = 0; i < NBANK; i++) bank_q[i] <= PAGE_W'(i);
            use_map_q  <= 1'b0;
            cpu_dout_q <= '0;
            cpu_ack_q  <= cpu_req;
            wr_pend_q  <= 1'b0;
            overrun_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            use_map_q  <= use_map_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_ack_q  <= cpu_ack_d;
            wr_pend_q  <= wr_pend_d;
            overrun_q  <= overrun_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    // Request toggles survive reset so an in-flight memory transaction can still be drained.
    always_ff @(posedge clk_sys) begin
        dl_active_q <= dl_active;
        if (!reset) begin
            mem_we_req_q <= mem_we_req_d;
            mem_rd_req_q <= mem_rd_req_d;
        end
    end

    assign cpu_ack        = cpu_ack_q;
    assign cpu_dout       = cpu_dout_q;
    assign dl_wait        = wr_pend_q;
    assign dl_overrun     = overrun_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_din    = mem_din_q;
    assign mem.mem_we_req = mem_we_req_q;
    assign mem.mem_rd_req = mem_rd_req_q;
endmodule

// File: tb/tb_rom_bank_mapper.sv
// tb/tb_rom_bank_mapper.sv - self-checking bench for rom_bank_mapper
module tb_rom_bank_mapper;
    localparam int MEM_W      = 25;
    localparam int DATA_W     = 16;
    localparam int LOCK_BANK0 = 1;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        map_we = 1'b0;
    logic [2:0]  map_a = '0;
    logic [5:0]  map_d = '0;
    logic [20:0] cpu_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_ack;
    logic [15:0] cpu_dout;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [15:0] dl_data = '0;
    logic        dl_wait;
    logic        dl_overrun;
`ifdef ROM_MAPPER_SIZE_MASK_EN
    logic [23:0] rom_mask = '1;
`endif

    rom_bank_mapper_if #(.MEM_W(MEM_W), .DATA_W(DATA_W)) mif ();

    rom_bank_mapper dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .map_we     (map_we),
        .map_a      (map_a),
        .map_d      (map_d),
        .cpu_addr   (cpu_addr),
        .cpu_req    (cpu_req),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .dl_overrun (dl_overrun),
`ifdef ROM_MAPPER_SIZE_MASK_EN
        .rom_mask   (rom_mask),
`endif
        .mem        (mif)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rom_word(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'hC3A5;
    endfunction

    // Reference bank table: expected translation from plain arithmetic on bank size.
    logic [5:0] ref_bank [8];
    bit         ref_use;

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_bank[i] = 6'(i);
        ref_use = 0;
    endtask

    task automatic ref_map_write(input logic [2:0] a, input logic [5:0] d);
        if (a != 0 || LOCK_BANK0 == 0) begin
            ref_bank[a] = d;
            ref_use = 1;
        end
    endtask

    function automatic logic [23:0] xlate(input logic [20:0] a);
        int bank;
        int off;
        bank = int'(a) / (1 << 18);
        off  = int'(a) % (1 << 18);
        if (!ref_use) return 24'(a);
        return 24'(int'(ref_bank[bank]) * (1 << 18) + off);
    endfunction

    // Memory model: acks after a programmable latency unless held.
    logic        hold = 1'b1;
    int          lat = 0;
    bit          rand_lat = 0;
    logic        force_en = 1'b0;
    logic [15:0] force_dout = '0;
    int          rd_cnt = 0;
    int          we_cnt = 0;
    int          overlap = 0;
    logic [23:0] rd_seen_addr = '0;
    logic [23:0] wr_seen_addr [$];
    logic [15:0] wr_seen_data [$];

    initial begin
        mif.mem_we_ack = 1'b0;
        mif.mem_rd_ack = 1'b0;
        mif.mem_dout   = '0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (mif.mem_rd_req != mif.mem_rd_ack && mif.mem_we_req != mif.mem_we_ack) overlap++;
            if (!hold && mif.mem_rd_req != mif.mem_rd_ack) begin
                if (rd_cnt >= lat) begin
                    mif.mem_dout   = force_en ? force_dout : rom_word(mif.mem_addr);
                    rd_seen_addr   = mif.mem_addr;
                    mif.mem_rd_ack = mif.mem_rd_req;
                    rd_cnt = 0;
                    if (rand_lat) lat = $urandom_range(0, 3);
                end else rd_cnt++;
            end
            if (!hold && mif.mem_we_req != mif.mem_we_ack) begin
                if (we_cnt >= lat) begin
                    wr_seen_addr.push_back(mif.mem_addr);
                    wr_seen_data.push_back(mif.mem_din);
                    mif.mem_we_ack = mif.mem_we_req;
                    we_cnt = 0;
                    if (rand_lat) lat = $urandom_range(0, 3);
                end else we_cnt++;
            end
        end
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (cpu_ack !== cpu_req && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: waited %0d cycles for cpu_ack, required fewer than 100", name, n);
        end
    endtask

    task automatic do_map(input logic [2:0] a, input logic [5:0] d);
        map_we = 1'b1;
        map_a  = a;
        map_d  = d;
        ref_map_write(a, d);
        tick();
        map_we = 1'b0;
    endtask

    task automatic do_read(input logic [20:0] a, input logic [23:0] exp, input string name);
        cpu_addr = a;
        cpu_req  = ~cpu_req;
        wait_ack(name);
        check({name, "_addr"}, rd_seen_addr, exp);
        check({name, "_data"}, cpu_dout, rom_word(exp));
    endtask

    task automatic pop_write(input logic [23:0] ea, input logic [15:0] ed, input string name);
        check({name, "_count"}, wr_seen_addr.size(), 1);
        if (wr_seen_addr.size() > 0) begin
            check({name, "_addr"}, wr_seen_addr.pop_front(), ea);
            check({name, "_data"}, wr_seen_data.pop_front(), ed);
        end
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  a;
        logic [5:0]  d;
        logic [20:0] addr;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_p;
        logic [23:0] rd_exp;
        logic [23:0] exp_wa [$];
        logic [15:0] exp_wd [$];
        bit          rd_out;
        int          tmo;

        vecs[0] = '{1'b1, 3'd0, 6'h3F, 21'h012345, 24'h012345};
        vecs[1] = '{1'b1, 3'd3, 6'h2A, 21'h0C0004, 24'hA80004};
        vecs[2] = '{1'b0, 3'd0, 6'h00, 21'h000010, 24'h000010};
        vecs[3] = '{1'b1, 3'd7, 6'h01, 21'h1FFFFF, 24'h07FFFF};
        vecs[4] = '{1'b0, 3'd0, 6'h00, 21'h0BFFFF, 24'h0BFFFF};
        vecs[5] = '{1'b1, 3'd0, 6'h15, 21'h000001, 24'h000001};
        vecs[6] = '{1'b1, 3'd5, 6'h3F, 21'h140000, 24'hFC0000};

        ref_reset();
        repeat (3) tick();
        check("rst_cpu_ack", cpu_ack, cpu_req);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_dl_wait", dl_wait, 0);
        check("rst_dl_overrun", dl_overrun, 0);
        check("rst_mem_addr", mif.mem_addr, 0);
        check("rst_mem_din", mif.mem_din, 0);

        // First read: one-cycle issue latency, ack returns on the edge after memory matches.
        force_en   = 1'b1;
        force_dout = 16'hBEEF;
        reset      = 1'b0;
        cpu_addr   = 21'h012345;
        cpu_req    = ~cpu_req;
        tick();
        check("rd1_issue", mif.mem_rd_req ^ mif.mem_rd_ack, 1);
        check("rd1_addr", mif.mem_addr, 24'h012345);
        hold = 1'b0;
        tick();
        check("rd1_mem_acked", mif.mem_rd_req ^ mif.mem_rd_ack, 0);
        check("rd1_cpu_ack_wait", cpu_ack ^ cpu_req, 1);
        tick();
        check("rd1_cpu_ack", cpu_ack ^ cpu_req, 0);
        check("rd1_cpu_dout", cpu_dout, 16'hBEEF);
        force_en = 1'b0;

        lat = 1;
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].we) do_map(vecs[i].a, vecs[i].d);
            do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Download capture, overrun and release.
        hold      = 1'b1;
        lat       = 0;
        dl_active = 1'b1;
        dl_wr     = 1'b1;
        dl_addr   = 25'h000010;
        dl_data   = 16'h1234;
        tick();
        dl_wr = 1'b0;
        check("dl_wait_set", dl_wait, 1);
        tick();
        check("dl_mem_addr", mif.mem_addr, 24'h000008);
        check("dl_mem_din", mif.mem_din, 16'h3412);
        check("dl_we_issue", mif.mem_we_req ^ mif.mem_we_ack, 1);
        dl_wr   = 1'b1;
        dl_addr = 25'h000020;
        dl_data = 16'h5678;
        tick();
        dl_wr = 1'b0;
        check("dl_overrun_set", dl_overrun, 1);
        check("dl_no_extra_we", mif.mem_we_req ^ mif.mem_we_ack, 1);
        hold = 1'b0;
        tick();
        check("dl_wait_hold", dl_wait, 1);
        tick();
        check("dl_wait_clear", dl_wait, 0);
        check("dl_overrun_sticky", dl_overrun, 1);
        pop_write(24'h000008, 16'h3412, "dl_wr");
        dl_active = 1'b0;
        tick();
        dl_active = 1'b1;
        tick();
        check("dl_overrun_cleared", dl_overrun, 0);

        // Write and read pending together in IDLE: write goes first.
        hold    = 1'b1;
        dl_wr   = 1'b1;
        dl_addr = 25'h0001FE;
        dl_data = 16'hA55A;
        tick();
        dl_wr    = 1'b0;
        cpu_addr = 21'h0C0010;
        cpu_req  = ~cpu_req;
        exp_p    = xlate(cpu_addr);
        tick();
        check("prio_wr_first", mif.mem_we_req ^ mif.mem_we_ack, 1);
        check("prio_rd_held", mif.mem_rd_req ^ mif.mem_rd_ack, 0);
        hold = 1'b0;
        tick();
        tick();
        check("prio_rd_not_yet", mif.mem_rd_req ^ mif.mem_rd_ack, 0);
        check("prio_dl_wait", dl_wait, 0);
        hold = 1'b1;
        tick();
        check("prio_rd_issue", mif.mem_rd_req ^ mif.mem_rd_ack, 1);
        check("prio_rd_addr", mif.mem_addr, exp_p);
        hold = 1'b0;
        wait_ack("prio_rd");
        check("prio_rd_data", cpu_dout, rom_word(exp_p));
        pop_write(24'h0000FF, 16'h5AA5, "prio_wr");

        // Reset in RD_WAIT: drain the old read, then identity table.
        hold     = 1'b1;
        cpu_addr = 21'h0C0004;
        cpu_req  = ~cpu_req;
        tick();
        check("drst_rd_pending", mif.mem_rd_req ^ mif.mem_rd_ack, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_reset();
        check("drst_cpu_ack", cpu_ack, cpu_req);
        check("drst_toggle_kept", mif.mem_rd_req ^ mif.mem_rd_ack, 1);
        check("drst_mem_addr", mif.mem_addr, 0);
        do_map(3'd6, 6'h11);
        cpu_addr = 21'h0C0004;
        cpu_req  = ~cpu_req;
        exp_p    = xlate(cpu_addr);
        repeat (3) begin
            tick();
            check("drain_no_rd", mif.mem_rd_req ^ mif.mem_rd_ack, 1);
            check("drain_no_we", mif.mem_we_req ^ mif.mem_we_ack, 0);
        end
        hold = 1'b0;
        wait_ack("drain_rd");
        check("drain_rd_addr", rd_seen_addr, 24'h0C0004);
        check("drain_rd_ref", exp_p, rd_seen_addr);
        check("drain_rd_data", cpu_dout, rom_word(exp_p));

        // Randomised traffic against the reference model.
        rand_lat = 1;
        rd_out   = 0;
        tmo      = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            map_we = 1'b0;
            dl_wr  = 1'b0;
            if (rd_out) begin
                if (cpu_ack == cpu_req) begin
                    check("rand_rd_data", cpu_dout, rom_word(rd_exp));
                    rd_out = 0;
                end else begin
                    tmo++;
                    if (tmo > 100) begin
                        checks++;
                        errors++;
                        $display("FAIL rand_rd_timeout: waited %0d cycles, required fewer than 100", tmo);
                        break;
                    end
                end
            end
            if (!dl_wait && $urandom_range(0, 3) == 0) begin
                dl_wr   = 1'b1;
                dl_addr = 25'($urandom);
                dl_data = 16'($urandom);
                exp_wa.push_back(dl_addr[24:1]);
                exp_wd.push_back({dl_data[7:0], dl_data[15:8]});
            end
            if (!rd_out) begin
                case ($urandom_range(0, 7))
                    0: begin
                        map_we = 1'b1;
                        map_a  = 3'($urandom);
                        map_d  = 6'($urandom);
                        ref_map_write(map_a, map_d);
                    end
                    1, 2, 3, 4: begin
                        cpu_addr = 21'($urandom);
                        cpu_req  = ~cpu_req;
                        rd_exp   = xlate(cpu_addr);
                        rd_out   = 1;
                        tmo      = 0;
                    end
                    default: ;
                endcase
            end
        end
        map_we = 1'b0;
        dl_wr  = 1'b0;
        repeat (30) tick();
        check("rand_wr_count", wr_seen_addr.size(), exp_wa.size());
        while (wr_seen_addr.size() > 0 && exp_wa.size() > 0) begin
            check("rand_wr_addr", wr_seen_addr.pop_front(), exp_wa.pop_front());
            check("rand_wr_data", wr_seen_data.pop_front(), exp_wd.pop_front());
        end
        check("single_outstanding", overlap, 0);
        check("rand_no_overrun", dl_overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_bank_mapper.md
Name: rom_bank_mapper

Overview:
- Parametrised successor to the fixed 8-slot cartridge bank table and the ioctl-to-DDR write handshake.
- Combines a generic N-bank ROM address mapper, a download write path with backpressure, and a single-outstanding-request arbiter onto one toggle-handshake memory port.
- Sits between the console core (ROM read side), hps_io ioctl (download side) and ddram.

Parameters:
- ADDR_W, 22: CPU byte-address width. CPU supplies word address bits [ADDR_W-1:1].
- BANK_SHIFT, 19: log2 of bank size in bytes. BANK_IDX_W = ADDR_W-BANK_SHIFT; number of banks = 2^BANK_IDX_W.
- PAGE_W, 6: bank register width. Memory byte-address width MEM_W = BANK_SHIFT+PAGE_W.
- DATA_W, 16: data width; must be even.
- LOCK_BANK0, 1: when 1, writes to bank index 0 are ignored and do not set the mapping-enable flag.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- map_we  in  1  bank register write strobe.
- map_a  in  BANK_IDX_W  bank index.
- map_d  in  PAGE_W  page number.
- cpu_addr  in  ADDR_W-1  CPU word address [ADDR_W-1:1].
- cpu_req  in  1  read request toggle.
- cpu_ack  out  1  read acknowledge toggle.
- cpu_dout  out  DATA_W  read data.
- dl_active  in  1  download in progress.
- dl_wr  in  1  download write pulse.
- dl_addr  in  MEM_W  download byte address; bit 0 ignored.
- dl_data  in  DATA_W  download data.
- dl_wait  out  1  download backpressure.
- dl_overrun  out  1  sticky; a dl_wr arrived while dl_wait=1.
- mem_addr  out  MEM_W-1  memory word address.
- mem_din  out  DATA_W  memory write data.
- mem_we_req  out  1  write request toggle.
- mem_we_ack  in  1  write acknowledge toggle.
- mem_rd_req  out  1  read request toggle.
- mem_rd_ack  in  1  read acknowledge toggle.
- mem_dout  in  DATA_W  memory read data.

Behaviour:
- Reset values: bank[i]=i (truncated to PAGE_W); use_map=0; cpu_dout=0; dl_wait=0; dl_overrun=0; mem_din=0; mem_addr=0; cpu_ack<=cpu_req (clears any pending CPU read).
- Reset does not modify mem_we_req or mem_rd_req.
- Reset state: FSM goes to DRAIN if either mem toggle pair mismatches, else IDLE.
- Bank write: map_we and not reset, with map_a!=0 or LOCK_BANK0=0 -> bank[map_a]<=map_d and use_map<=1 on the next edge.
- Translation, captured when a read is accepted:
  - use_map=0 -> mem word address = zero-extended cpu_addr.
  - use_map=1 -> {bank[cpu_addr[ADDR_W-1:BANK_SHIFT]], cpu_addr[BANK_SHIFT-1:1]}.
  - A bank write in the same cycle as acceptance is not seen by that read.
- Download capture: dl_wr with dl_wait=0 -> latch dl_addr[MEM_W-1:1] and byte-swapped dl_data ({low byte, high byte}), set dl_wait=1, set write-pending.
- Overrun: dl_wr with dl_wait=1 -> write dropped, dl_overrun<=1. dl_overrun clears only on reset or a rising edge of dl_active.
- Rising edge of dl_active clears dl_overrun only; toggles are untouched.
- FSM IDLE:
  - Write-pending -> drive mem_addr/mem_din, toggle mem_we_req, go to WR_WAIT. Write has priority over read.
  - Else cpu_req!=cpu_ack -> drive translated mem_addr, toggle mem_rd_req, go to RD_WAIT.
- FSM WR_WAIT: mem_we_ack==mem_we_req -> clear write-pending, dl_wait<=0, go to IDLE. The next dl_wr is accepted in the cycle after dl_wait falls.
- FSM RD_WAIT: mem_rd_ack==mem_rd_req -> cpu_dout<=mem_dout, cpu_ack<=~cpu_ack, go to IDLE.
- FSM DRAIN: both pairs match -> IDLE. No new requests issue while in DRAIN.
- Latency:
  - Read: mem_rd_req toggles 1 cycle after cpu_req toggles (if IDLE and no write pending).
  - cpu_ack toggles on the edge after mem_rd_ack matches.
  - Back-to-back read: minimum 3 cycles per read when memory acks in 1 cycle.
- Exactly one memory request outstanding at any time.
- cpu_req toggling again before cpu_ack: protocol violation, behaviour undefined.

Optional Feature:
- Macro: ROM_MAPPER_SIZE_MASK_EN.
- Defined: adds input rom_mask (width MEM_W-1). Read mem_addr = translated address AND rom_mask, giving mirroring of small ROMs. Download writes are unmasked.
- Undefined: no port, no masking.

Test Plan:
- Reset, then cpu_req toggle with cpu_addr=0x012345 (word), use_map=0 -> mem_addr=0x012345, mem_rd_req toggles next cycle. Ack with mem_dout=0xBEEF -> cpu_dout=0xBEEF, cpu_ack toggles one cycle later.
- map_we, map_a=3, map_d=0x2A, then read word address 0x0C0004 (bank 3, offset 0x4) -> mem_addr={6'h2A,18'h00004}. map_a=0 write with LOCK_BANK0=1 -> table unchanged, use_map stays 0.
- dl_wr with dl_addr=0x000010, dl_data=0x1234 -> dl_wait=1, mem_addr=0x8, mem_din=0x3412, mem_we_req toggles. Ack -> dl_wait=0 next cycle.
- Second dl_wr while dl_wait=1 -> no extra mem_we_req toggle, dl_overrun=1 until next dl_active rise.
- Write pending and CPU read pending in IDLE in the same cycle -> write issued first, read issued the cycle after write ack.
- Reset asserted while RD_WAIT -> cpu_ack==cpu_req, FSM in DRAIN, no request issued until mem_rd_ack matches. Then IDLE, and bank table is identity.
